// File: rtl/sdram_port_arbiter_if.sv
// Client-side bus of the SDRAM port arbiter: per-channel request/qualifier
// inputs and the completion/read-data outputs. Each channel's address and
// write data are packed into a flattened vector, one slice per channel.
interface sdram_port_arbiter_if #(
  parameter int NCH = 3,
  parameter int AW  = 25,
  parameter int DW  = 8
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    ack;
  logic [NCH-1:0]    rvalid;
  logic [DW-1:0]     rdata;

  // Clients drive requests and consume completions.
  modport master (
    output req, we, addr, din,
    input  ack, rvalid, rdata
  );

  // The arbiter consumes requests and drives completions.
  modport slave (
    input  req, we, addr, din,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// N-channel arbiter multiplexing byte-wide clients onto the single SDRAM
// controller port. Channel 0 is the ROM download channel and can be given
// exclusive access with lock_ch0. Policy is fixed priority or round-robin.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | arbitrate among eligible requests; latch winner on grant
// ACCESS  | hold strobe, address and data for ACC_CYC cycles; ack on last
// RECOVER | one cycle with both strobes low before the next arbitration
module sdram_port_arbiter #(
  parameter int NCH     = 3,
  parameter int AW      = 25,
  parameter int DW      = 8,
  parameter int ACC_CYC = 4,
  parameter int RR_MODE = 0,
  localparam int GW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CW     = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1
) (
  input  logic                 F14M,
  input  logic                 RESET,
  sdram_port_arbiter_if.slave  clients,
  input  logic                 lock_ch0,
  output logic [AW-1:0]        sd_addr,
  output logic [DW-1:0]        sd_din,
  output logic                 sd_we,
  output logic                 sd_oe,
  input  logic [DW-1:0]        sd_dout,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [GW-1:0]  rr_ptr;
  logic           cur_we;
  logic [NCH-1:0] ack_q;
  logic [NCH-1:0] rvalid_q;
  logic [DW-1:0]  rdata_q;

  logic [NCH-1:0] elig;
  logic           found;
  logic [GW-1:0]  win;

  assign clients.ack    = ack_q;
  assign clients.rvalid = rvalid_q;
  assign clients.rdata  = rdata_q;

  // Winner selection: lowest eligible index, or first eligible at/after
  // the round-robin pointer. The lock narrows eligibility to channel 0.
  always_comb begin
    elig  = clients.req;
    found = 1'b0;
    win   = '0;
    if (lock_ch0) elig = clients.req & NCH'(1);
    if (RR_MODE != 0) begin
      for (int k = 0; k < NCH; k++) begin
        if (!found && elig[(int'(rr_ptr) + k) % NCH]) begin
          found = 1'b1;
          win   = GW'((int'(rr_ptr) + k) % NCH);
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (elig[k]) begin
          found = 1'b1;
          win   = GW'(k);
        end
      end
    end
  end

  // Arbitration FSM with registered strobes, completion pulses and read data.
  // ack/rvalid are set on the edge that brings the counter to 0 so they line
  // up with the final strobe cycle; rdata is sampled on that same edge.
  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      cur_we   <= 1'b0;
      ack_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_we    <= 1'b0;
      sd_oe    <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
    end else begin
      ack_q    <= '0;
      rvalid_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= win;
            sd_addr  <= clients.addr[int'(win)*AW +: AW];
            sd_din   <= clients.din[int'(win)*DW +: DW];
            cur_we   <= clients.we[win];
            sd_we    <= clients.we[win];
            sd_oe    <= !clients.we[win];
            busy     <= 1'b1;
            cnt      <= CW'(ACC_CYC - 1);
            rr_ptr   <= (int'(win) == NCH - 1) ? '0 : win + 1'b1;
            state    <= ACCESS;
            // A single-cycle access completes in its only strobe cycle.
            if (ACC_CYC == 1) begin
              ack_q[win] <= 1'b1;
              if (!clients.we[win]) begin
                rvalid_q[win] <= 1'b1;
                rdata_q       <= sd_dout;
              end
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            sd_we <= 1'b0;
            sd_oe <= 1'b0;
            state <= RECOVER;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              ack_q[grant_id] <= 1'b1;
              if (!cur_we) begin
                rvalid_q[grant_id] <= 1'b1;
                rdata_q            <= sd_dout;
              end
            end
          end
        end
        RECOVER: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: one fixed-priority instance and one
// round-robin instance sharing clock and reset. Each memory port returns
// sd_addr[7:0] ^ 8'h43 as read data.
module tb_sdram_port_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 25;
  localparam int DW  = 8;

  logic F14M = 1'b0;
  logic RESET = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  // fixed-priority instance
  sdram_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus_fp ();
  logic          fp_lock;
  logic [AW-1:0] fp_sd_addr;
  logic [DW-1:0] fp_sd_din;
  logic          fp_sd_we, fp_sd_oe, fp_busy;
  logic [DW-1:0] fp_sd_dout;
  logic [1:0]    fp_grant;

  // round-robin instance
  sdram_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus_rr ();
  logic          rr_lock;
  logic [AW-1:0] rr_sd_addr;
  logic [DW-1:0] rr_sd_din;
  logic          rr_sd_we, rr_sd_oe, rr_busy;
  logic [DW-1:0] rr_sd_dout;
  logic [1:0]    rr_grant;

  assign fp_sd_dout = fp_sd_addr[7:0] ^ 8'h43;
  assign rr_sd_dout = rr_sd_addr[7:0] ^ 8'h43;

  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .ACC_CYC(4), .RR_MODE(0)) u_fp (
    .F14M(F14M), .RESET(RESET), .clients(bus_fp), .lock_ch0(fp_lock),
    .sd_addr(fp_sd_addr), .sd_din(fp_sd_din), .sd_we(fp_sd_we), .sd_oe(fp_sd_oe),
    .sd_dout(fp_sd_dout), .busy(fp_busy), .grant_id(fp_grant)
  );

  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .ACC_CYC(4), .RR_MODE(1)) u_rr (
    .F14M(F14M), .RESET(RESET), .clients(bus_rr), .lock_ch0(rr_lock),
    .sd_addr(rr_sd_addr), .sd_din(rr_sd_din), .sd_we(rr_sd_we), .sd_oe(rr_sd_oe),
    .sd_dout(rr_sd_dout), .busy(rr_busy), .grant_id(rr_grant)
  );

  always #5 F14M = ~F14M;

  task automatic tick();
    @(posedge F14M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [19:0] we_log;
    logic [1:0]  g_log [9];
    logic [7:0]  d_log [3];
    int          n_ack;
    int          n0;
    bit          found;
    bit          raise0;

    bus_fp.req = '0; bus_fp.we = '0; bus_fp.addr = '0; bus_fp.din = '0;
    bus_rr.req = '0; bus_rr.we = '0; bus_rr.addr = '0; bus_rr.din = '0;
    fp_lock = 1'b0;
    rr_lock = 1'b0;

    // ---- reset then idle ----
    #1;
    chk("reset_busy", 32'(fp_busy), 32'd0);
    repeat (3) tick();
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outs", 32'({bus_fp.ack, bus_fp.rvalid, bus_fp.rdata, fp_sd_we, fp_sd_oe, fp_busy, fp_grant}), 32'd0);
    end
    chk("idle_sd_addr", 32'(fp_sd_addr), 32'd0);
    chk("idle_sd_din", 32'(fp_sd_din), 32'd0);
    chk("idle_rr_busy", 32'({rr_busy, rr_sd_we, rr_sd_oe}), 32'd0);

    // ---- single read, ch1 ----
    bus_fp.addr[1*AW +: AW] = 25'h1C3801;
    bus_fp.we[1] = 1'b0;
    bus_fp.req[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("rd_oe_c%0d", k), 32'(fp_sd_oe), (k <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("rd_ack_c%0d", k), 32'(bus_fp.ack), (k == 4) ? 32'd2 : 32'd0);
      chk($sformatf("rd_rvalid_c%0d", k), 32'(bus_fp.rvalid), (k == 4) ? 32'd2 : 32'd0);
      chk($sformatf("rd_busy_c%0d", k), 32'(fp_busy), (k <= 5) ? 32'd1 : 32'd0);
      if (k == 1) begin
        chk("rd_sd_addr", 32'(fp_sd_addr), 32'h01C3801);
        chk("rd_grant", 32'(fp_grant), 32'd1);
      end
      if (bus_fp.ack[1]) bus_fp.req[1] = 1'b0;
    end
    chk("rd_rdata", 32'(bus_fp.rdata), 32'h42);
    chk("rd_sd_we", 32'(fp_sd_we), 32'd0);

    // ---- fixed priority, three simultaneous writes ----
    bus_fp.addr = {25'h0000300, 25'h0000200, 25'h0000100};
    bus_fp.din  = {8'h43, 8'h42, 8'h41};
    bus_fp.we   = 3'b111;
    bus_fp.req  = 3'b111;
    we_log = '0;
    n_ack = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      we_log[k-1] = fp_sd_we;
      if (bus_fp.ack != '0) begin
        if (n_ack < 3) begin
          g_log[n_ack] = fp_grant;
          d_log[n_ack] = fp_sd_din;
        end
        n_ack++;
        bus_fp.req = bus_fp.req & ~bus_fp.ack;
      end
    end
    chk("fp_n_ack", 32'(n_ack), 32'd3);
    chk("fp_we_pattern", 32'(we_log), 32'h0F3CF);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fp_grant_%0d", i), 32'(g_log[i]), 32'(i));
      chk($sformatf("fp_din_%0d", i), 32'(d_log[i]), 32'h41 + 32'(i));
    end

    // ---- round robin, continuous requests ----
    bus_rr.we   = 3'b111;
    bus_rr.din  = {8'h13, 8'h12, 8'h11};
    bus_rr.req  = 3'b111;
    n_ack = 0;
    for (int k = 0; k < 80 && n_ack < 9; k++) begin
      tick();
      if (bus_rr.ack != '0) begin
        g_log[n_ack] = rr_grant;
        n_ack++;
      end
    end
    bus_rr.req = '0;
    chk("rr_n_ack", 32'(n_ack), 32'd9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("rr_grant_%0d", i), 32'(g_log[i]), 32'(i % 3));
    repeat (8) tick();

    // ---- lock_ch0 with ch1/ch2 waiting ----
    bus_fp.addr = {25'h0000010, 25'h0000020, 25'h0000030};
    bus_fp.din  = {8'h00, 8'h00, 8'hA0};
    bus_fp.we   = 3'b001;
    fp_lock     = 1'b1;
    bus_fp.req  = 3'b111;
    n0 = 0;
    raise0 = 1'b0;
    for (int k = 0; k < 40 && n0 < 3; k++) begin
      tick();
      if (raise0) begin
        bus_fp.req[0] = 1'b1;
        raise0 = 1'b0;
      end
      if (bus_fp.ack != '0) begin
        chk("lock_ack_ch0", 32'(bus_fp.ack), 32'd1);
        n0++;
        bus_fp.req[0] = 1'b0;
        raise0 = (n0 < 3);
      end
    end
    chk("lock_n_ch0", 32'(n0), 32'd3);
    tick();
    fp_lock = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2 && !found; k++) begin
      tick();
      if (fp_busy && fp_grant == 2'd1) found = 1'b1;
    end
    chk("unlock_grant_ch1", 32'(found), 32'd1);
    n_ack = 0;
    for (int k = 0; k < 40 && n_ack < 2; k++) begin
      if (bus_fp.ack != '0) begin
        chk($sformatf("unlock_ack_%0d", n_ack), 32'(bus_fp.ack), (n_ack == 0) ? 32'd2 : 32'd4);
        chk($sformatf("unlock_rvalid_%0d", n_ack), 32'(bus_fp.rvalid), 32'(bus_fp.ack));
        n_ack++;
        bus_fp.req = bus_fp.req & ~bus_fp.ack;
      end
      if (n_ack < 2) tick();
    end
    chk("unlock_n_ack", 32'(n_ack), 32'd2);
    chk("unlock_rdata", 32'(bus_fp.rdata), 32'h53);
    repeat (6) tick();

    // ---- reset during a ch2 write ----
    bus_fp.addr[2*AW +: AW] = 25'h0000777;
    bus_fp.din[2*DW +: DW]  = 8'h5A;
    bus_fp.we[2]  = 1'b1;
    bus_fp.req    = 3'b100;
    tick();
    tick();
    chk("rst_pre_we", 32'(fp_sd_we), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_we_drop", 32'(fp_sd_we), 32'd0);
    chk("rst_busy_drop", 32'(fp_busy), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_no_ack", 32'(bus_fp.ack), 32'd0);
    end
    RESET = 1'b0;
    n_ack = 0;
    for (int k = 1; k <= 20 && n_ack == 0; k++) begin
      tick();
      if (bus_fp.ack != '0) begin
        n_ack = k;
        chk("rst_regrant_ack", 32'(bus_fp.ack), 32'd4);
        chk("rst_regrant_din", 32'(fp_sd_din), 32'h5A);
        chk("rst_regrant_gid", 32'(fp_grant), 32'd2);
        bus_fp.req = '0;
      end
    end
    chk("rst_regrant_latency", 32'(n_ack), 32'd4);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
